// File: rtl/neuron_tdm_scheduler.sv
// Time-multiplexed neuron update scheduler: one external datapath is shared by all
// neuron slots. Each tick starts an in-order sweep, and spike events are queued in a small FIFO.
module neuron_tdm_scheduler #(
   parameter int NUM_NEURONS   = 4,
   parameter int IDX_W         = 2,
   parameter int STATE_W       = 8,
   parameter int REFRACT_TICKS = 3,
   parameter int FIFO_DEPTH    = 4
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               tick,
   input  logic               cfg_we,
   input  logic [IDX_W-1:0]   cfg_addr,
   input  logic [STATE_W-1:0] cfg_stim,
   input  logic [IDX_W-1:0]   mon_addr,
   output logic [STATE_W-1:0] mon_state,
   output logic               dp_req,
   output logic [IDX_W-1:0]   dp_idx,
   output logic [STATE_W-1:0] dp_state,
   output logic [STATE_W-1:0] dp_stim,
   input  logic               dp_ack,
   input  logic [STATE_W-1:0] dp_next_state,
   input  logic               dp_spike,
   output logic               spk_valid,
   output logic [IDX_W-1:0]   spk_idx,
   input  logic               spk_ready,
   output logic               busy,
   output logic               tick_overrun,
   output logic               spk_overflow,
   output logic [7:0]         sweep_count
);

   localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
   localparam logic [IDX_W-1:0] LAST_IDX      = IDX_W'(NUM_NEURONS - 1);
   localparam logic [CNT_W-1:0] FIFO_FULL_CNT = CNT_W'(FIFO_DEPTH);
   localparam logic [3:0]       REFRACT_LOAD  = 4'(REFRACT_TICKS);

   typedef enum logic [0:0] {
      IDLE  = 1'b0,
      ISSUE = 1'b1
   } fsm_t;

   fsm_t               fsm_r;
   fsm_t               fsm_next_s;
   logic [IDX_W-1:0]   idx_r;
   logic [IDX_W-1:0]   idx_next_s;
   logic [STATE_W-1:0] state_r   [NUM_NEURONS];
   logic [STATE_W-1:0] stim_r    [NUM_NEURONS];
   logic [3:0]         refract_r [NUM_NEURONS];

   logic [IDX_W-1:0]   fifo_mem_r [FIFO_DEPTH];
   logic [PTR_W-1:0]   wr_ptr_r;
   logic [PTR_W-1:0]   rd_ptr_r;
   logic [CNT_W-1:0]   fifo_cnt_r;

   logic [7:0]         sweep_count_r;
   logic               tick_overrun_r;
   logic               spk_overflow_r;

   logic               req_s;
   logic               skip_s;
   logic               transfer_s;
   logic               sweep_done_s;
   logic               push_s;
   logic               pop_s;
   logic               fifo_full_s;
   logic               push_ok_s;
   logic               drop_s;

   // Sweep sequencing: decide skip/request for the current slot and where to go next
   always_comb begin
      fsm_next_s   = fsm_r;
      idx_next_s   = idx_r;
      req_s        = 1'b0;
      skip_s       = 1'b0;
      transfer_s   = 1'b0;
      sweep_done_s = 1'b0;
      case (fsm_r)
         IDLE: begin
            if (tick) begin
               fsm_next_s = ISSUE;
               idx_next_s = '0;
            end else begin
               fsm_next_s = IDLE;
            end
         end
         ISSUE: begin
            if (refract_r[idx_r] != 4'd0) begin
               skip_s = 1'b1;
            end else begin
               req_s      = 1'b1;
               transfer_s = dp_ack;
            end
            if ((refract_r[idx_r] != 4'd0) || dp_ack) begin
               if (idx_r == LAST_IDX) begin
                  fsm_next_s   = IDLE;
                  idx_next_s   = '0;
                  sweep_done_s = 1'b1;
               end else begin
                  idx_next_s = idx_r + IDX_W'(1);
               end
            end else begin
               idx_next_s = idx_r;
            end
         end
         default: begin
            fsm_next_s = IDLE;
            idx_next_s = '0;
         end
      endcase
   end

   assign push_s      = transfer_s && dp_spike;
   assign pop_s       = (fifo_cnt_r != '0) && spk_ready;
   assign fifo_full_s = (fifo_cnt_r == FIFO_FULL_CNT);
   // A pop in the same cycle frees a slot, so a push into a full FIFO still lands
   assign push_ok_s   = push_s && (!fifo_full_s || pop_s);
   assign drop_s      = push_s && fifo_full_s && !pop_s;

   // FSM, sweep index, sweep counter and sticky status flags
   always_ff @(posedge clk) begin
      if (rst) begin
         fsm_r          <= IDLE;
         idx_r          <= '0;
         sweep_count_r  <= 8'd0;
         tick_overrun_r <= 1'b0;
         spk_overflow_r <= 1'b0;
      end else begin
         fsm_r <= fsm_next_s;
         idx_r <= idx_next_s;
         if (sweep_done_s) begin
            sweep_count_r <= sweep_count_r + 8'd1;
         end
         if ((fsm_r == ISSUE) && tick) begin
            tick_overrun_r <= 1'b1;
         end
         if (drop_s) begin
            spk_overflow_r <= 1'b1;
         end
      end
   end

   // Per-neuron storage: stimulus config, writeback on transfer, refractory skip
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < NUM_NEURONS; i++) begin
            state_r[i]   <= '0;
            stim_r[i]    <= '0;
            refract_r[i] <= 4'd0;
         end
      end else begin
         if (cfg_we) begin
            stim_r[cfg_addr] <= cfg_stim;
         end
         if (skip_s) begin
            refract_r[idx_r] <= refract_r[idx_r] - 4'd1;
            state_r[idx_r]   <= '0;
         end else if (transfer_s) begin
            if (dp_spike) begin
               state_r[idx_r]   <= '0;
               refract_r[idx_r] <= REFRACT_LOAD;
            end else begin
               state_r[idx_r] <= dp_next_state;
            end
         end
      end
   end

   // Spike event FIFO: circular buffer with occupancy count
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_r   <= '0;
         rd_ptr_r   <= '0;
         fifo_cnt_r <= '0;
         for (int i = 0; i < FIFO_DEPTH; i++) begin
            fifo_mem_r[i] <= '0;
         end
      end else begin
         if (push_ok_s) begin
            fifo_mem_r[wr_ptr_r] <= idx_r;
            wr_ptr_r             <= wr_ptr_r + PTR_W'(1);
         end
         if (pop_s) begin
            rd_ptr_r <= rd_ptr_r + PTR_W'(1);
         end
         case ({push_ok_s, pop_s})
            2'b10:   fifo_cnt_r <= fifo_cnt_r + CNT_W'(1);
            2'b01:   fifo_cnt_r <= fifo_cnt_r - CNT_W'(1);
            default: fifo_cnt_r <= fifo_cnt_r;
         endcase
      end
   end

   assign busy         = (fsm_r == ISSUE);
   assign dp_req       = req_s;
   assign dp_idx       = idx_r;
   assign dp_state     = state_r[idx_r];
   assign dp_stim      = stim_r[idx_r];
   assign mon_state    = state_r[mon_addr];
   assign spk_valid    = (fifo_cnt_r != '0);
   assign spk_idx      = fifo_mem_r[rd_ptr_r];
   assign tick_overrun = tick_overrun_r;
   assign spk_overflow = spk_overflow_r;
   assign sweep_count  = sweep_count_r;

endmodule

// File: tb/tb_neuron_tdm_scheduler.sv
// Self-checking bench for neuron_tdm_scheduler: directed scenarios plus randomized sweeps
// checked against a sweep-level reference model of neuron slots and the spike queue.
module tb_neuron_tdm_scheduler;

   localparam int N     = 4;
   localparam int R     = 3;
   localparam int DEPTH = 4;

   logic       clk;
   logic       rst;
   logic       tick;
   logic       cfg_we;
   logic [1:0] cfg_addr;
   logic [7:0] cfg_stim;
   logic [1:0] mon_addr;
   logic [7:0] mon_state;
   logic       dp_req;
   logic [1:0] dp_idx;
   logic [7:0] dp_state;
   logic [7:0] dp_stim;
   logic       dp_ack;
   logic [7:0] dp_next_state;
   logic       dp_spike;
   logic       spk_valid;
   logic [1:0] spk_idx;
   logic       spk_ready;
   logic       busy;
   logic       tick_overrun;
   logic       spk_overflow;
   logic [7:0] sweep_count;

   neuron_tdm_scheduler dut (
      .clk(clk), .rst(rst), .tick(tick),
      .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_stim(cfg_stim),
      .mon_addr(mon_addr), .mon_state(mon_state),
      .dp_req(dp_req), .dp_idx(dp_idx), .dp_state(dp_state), .dp_stim(dp_stim),
      .dp_ack(dp_ack), .dp_next_state(dp_next_state), .dp_spike(dp_spike),
      .spk_valid(spk_valid), .spk_idx(spk_idx), .spk_ready(spk_ready),
      .busy(busy), .tick_overrun(tick_overrun), .spk_overflow(spk_overflow),
      .sweep_count(sweep_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference model
   logic [7:0] m_st [N];
   logic [7:0] m_sm [N];
   int         m_rf [N];
   logic [1:0] m_q [$];
   int         m_cnt;
   bit         m_ovr;
   bit         m_ovf;
   int         ready_mode;   // 0 never pop, 1 random, 2 pop on ack cycles, 3 always
   bit         rand_cfg;

   int n_checks;
   int n_fail;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < N; i++) begin
         m_st[i] = 8'd0;
         m_sm[i] = 8'd0;
         m_rf[i] = 0;
      end
      m_q.delete();
      m_cnt = 0;
      m_ovr = 1'b0;
      m_ovf = 1'b0;
   endtask

   // One clock: check FIFO head, choose spk_ready, advance the queue model, then clock
   task automatic tick_cycle(input bit push, input logic [1:0] pidx, input bit ack_cyc);
      bit pop;
      check_eq("spk_valid", spk_valid, (m_q.size() != 0) ? 1 : 0);
      if (m_q.size() != 0) check_eq("spk_idx", spk_idx, m_q[0]);
      case (ready_mode)
         1:       spk_ready = 1'($urandom_range(1, 0));
         2:       spk_ready = ack_cyc;
         3:       spk_ready = 1'b1;
         default: spk_ready = 1'b0;
      endcase
      pop = spk_ready && (m_q.size() != 0);
      if (cfg_we) m_sm[cfg_addr] = cfg_stim;
      if (pop) void'(m_q.pop_front());
      if (push) begin
         if (m_q.size() < DEPTH) m_q.push_back(pidx);
         else m_ovf = 1'b1;
      end
      @(posedge clk);
      @(negedge clk);
      tick      = 1'b0;
      cfg_we    = 1'b0;
      dp_ack    = 1'b0;
      dp_spike  = 1'b0;
      spk_ready = 1'b0;
   endtask

   task automatic check_mon();
      for (int a = 0; a < N; a++) begin
         mon_addr = 2'(a);
         #1;
         check_eq("mon_state", mon_state, m_st[a]);
      end
   endtask

   task automatic check_cleared();
      check_eq("rst_dp_req", dp_req, 1'b0);
      check_eq("rst_busy", busy, 1'b0);
      check_eq("rst_spk_valid", spk_valid, 1'b0);
      check_eq("rst_overrun", tick_overrun, 1'b0);
      check_eq("rst_overflow", spk_overflow, 1'b0);
      check_eq("rst_sweep_count", sweep_count, 8'd0);
      for (int a = 0; a < N; a++) begin
         mon_addr = 2'(a);
         #1;
         check_eq("rst_mon_state", mon_state, 8'd0);
      end
   endtask

   task automatic run_sweep(input int dmin, input int dmax, input logic [3:0] mask,
                            input bit tick_mid);
      int d;
      bit spk;
      check_eq("idle_before_tick", busy, 1'b0);
      tick = 1'b1;
      tick_cycle(1'b0, 2'd0, 1'b0);
      for (int k = 0; k < N; k++) begin
         check_eq("busy_in_sweep", busy, 1'b1);
         if (m_rf[k] != 0) begin
            check_eq("skip_no_req", dp_req, 1'b0);
            dp_ack   = 1'($urandom_range(1, 0));
            dp_spike = 1'($urandom_range(1, 0));
            m_rf[k]--;
            m_st[k] = 8'd0;
            tick_cycle(1'b0, 2'd0, 1'b0);
         end else begin
            d = $urandom_range(dmax, dmin);
            for (int h = 0; h < d; h++) begin
               check_eq("hold_req", dp_req, 1'b1);
               check_eq("hold_idx", dp_idx, k);
               check_eq("hold_state", dp_state, m_st[k]);
               check_eq("hold_stim", dp_stim, m_sm[k]);
               if (tick_mid && k == 1 && h == 0) begin
                  tick  = 1'b1;
                  m_ovr = 1'b1;
               end
               if (rand_cfg && $urandom_range(2, 0) == 0) begin
                  cfg_we   = 1'b1;
                  cfg_addr = 2'($urandom_range(N - 1, 0));
                  cfg_stim = 8'($urandom_range(255, 0));
               end
               dp_spike = 1'($urandom_range(1, 0));
               tick_cycle(1'b0, 2'd0, 1'b0);
            end
            check_eq("ack_req", dp_req, 1'b1);
            check_eq("ack_idx", dp_idx, k);
            check_eq("ack_state", dp_state, m_st[k]);
            check_eq("ack_stim", dp_stim, m_sm[k]);
            spk           = mask[k];
            dp_ack        = 1'b1;
            dp_next_state = m_st[k] + m_sm[k];
            dp_spike      = spk;
            if (spk) begin
               m_st[k] = 8'd0;
               m_rf[k] = R;
            end else begin
               m_st[k] = m_st[k] + m_sm[k];
            end
            tick_cycle(spk, 2'(k), 1'b1);
         end
      end
      check_eq("busy_drop", busy, 1'b0);
      m_cnt++;
      check_eq("sweep_count", sweep_count, m_cnt & 255);
      check_eq("tick_overrun", tick_overrun, m_ovr);
      check_eq("spk_overflow", spk_overflow, m_ovf);
      check_mon();
      tick_cycle(1'b0, 2'd0, 1'b0);
      check_eq("no_extra_sweep", busy, 1'b0);
   endtask

   task automatic drain();
      int saved;
      saved      = ready_mode;
      ready_mode = 3;
      for (int i = 0; i < DEPTH + 1 && m_q.size() != 0; i++) begin
         tick_cycle(1'b0, 2'd0, 1'b0);
      end
      check_eq("drain_empty", spk_valid, 1'b0);
      ready_mode = saved;
   endtask

   task automatic cfg_write(input logic [1:0] a, input logic [7:0] v);
      cfg_we   = 1'b1;
      cfg_addr = a;
      cfg_stim = v;
      tick_cycle(1'b0, 2'd0, 1'b0);
   endtask

   initial begin
      bit found;
      n_checks = 0;
      n_fail   = 0;
      rst = 1'b1; tick = 1'b0; cfg_we = 1'b0; cfg_addr = 2'd0; cfg_stim = 8'd0;
      mon_addr = 2'd0; dp_ack = 1'b0; dp_next_state = 8'd0; dp_spike = 1'b0;
      spk_ready = 1'b0; ready_mode = 0; rand_cfg = 1'b0;
      model_reset();
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      check_cleared();

      // Immediate ack, accumulate stimulus
      for (int i = 0; i < N; i++) cfg_write(2'(i), 8'(10 * (i + 1)));
      run_sweep(0, 0, 4'b0000, 1'b0);
      for (int a = 0; a < N; a++) begin
         mon_addr = 2'(a);
         #1;
         check_eq("t1_state", mon_state, 10 * (a + 1));
      end

      // Three-cycle ack latency with an overrunning tick
      run_sweep(3, 3, 4'b0000, 1'b1);
      check_eq("t2_overrun", tick_overrun, 1'b1);

      // Neuron 2 spikes, then sits out three sweeps
      run_sweep(0, 1, 4'b0100, 1'b0);
      check_eq("t3_spk_valid", spk_valid, 1'b1);
      check_eq("t3_spk_idx", spk_idx, 2'd2);
      for (int s = 0; s < 4; s++) run_sweep(0, 1, 4'b0000, 1'b0);
      drain();

      // Fill FIFO, then full FIFO with simultaneous pop, then overflow, then drain in order
      run_sweep(0, 0, 4'b1111, 1'b0);
      for (int s = 0; s < R; s++) run_sweep(0, 0, 4'b0000, 1'b0);
      ready_mode = 2;
      run_sweep(0, 2, 4'b1111, 1'b0);
      check_eq("t5_no_overflow", spk_overflow, 1'b0);
      ready_mode = 0;
      for (int s = 0; s < R; s++) run_sweep(0, 0, 4'b0000, 1'b0);
      run_sweep(0, 0, 4'b1111, 1'b0);
      check_eq("t4_overflow", spk_overflow, 1'b1);
      drain();
      for (int s = 0; s < R; s++) run_sweep(0, 0, 4'b0000, 1'b0);

      // Reset during a stalled request
      tick = 1'b1;
      tick_cycle(1'b0, 2'd0, 1'b0);
      found = 1'b0;
      for (int i = 0; i < 8 && !found; i++) begin
         if (dp_req) found = 1'b1;
         else tick_cycle(1'b0, 2'd0, 1'b0);
      end
      check_eq("t6_req_seen", found, 1'b1);
      repeat (2) tick_cycle(1'b0, 2'd0, 1'b0);
      rst = 1'b1;
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      model_reset();
      check_cleared();
      rand_cfg = 1'b1;
      run_sweep(0, 2, 4'b0000, 1'b0);

      // Randomized sweeps
      ready_mode = 1;
      for (int s = 0; s < 40; s++) begin
         logic [3:0] mask;
         for (int b = 0; b < N; b++) mask[b] = ($urandom_range(3, 0) == 0);
         for (int c = 0; c < 2; c++) begin
            if ($urandom_range(1, 0) == 1)
               cfg_write(2'($urandom_range(N - 1, 0)), 8'($urandom_range(255, 0)));
         end
         run_sweep(0, 3, mask, ($urandom_range(4, 0) == 0));
      end
      drain();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
